// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state type and the default datapath width.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> mul/div unit signal bundle; master is the pipeline side,
// slave is the sequencer.
interface muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             rd_req;
  logic             flush;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, rd_req, flush,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, rd_req, flush,
    output busy, done, stall, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational step of the unsigned shift-add multiply or the
// restoring divide, operating on the {acc,low} register pair.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] low_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Multiply consumes the multiplier LSB-first from low; divide shifts the
  // dividend MSB-first out of low into acc and shifts quotient bits back in.
  always_comb begin
    sum      = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
    shifted  = {acc, low[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, operand};
    acc_next = sum[WIDTH:1];
    low_next = {sum[0], low[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH+1:WIDTH] == 2'b00) begin
        acc_next = diff[WIDTH-1:0];
        low_next = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        low_next = {low[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; also
// services MTHI/MTLO and stalls EX while a sequence is in flight.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] rs_hold;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             sign_a;
  logic             sign_b;
  logic             is_div;
  logic             div_zero;
  logic             done_q;

  logic             accept;
  logic             is_muldiv;
  logic             signed_op;
  logic             last_iter;
  logic [WIDTH-1:0] mag_rs;
  logic [WIDTH-1:0] mag_rt;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] low_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (is_div),
    .acc      (acc),
    .low      (low),
    .operand  (operand),
    .acc_next (acc_next),
    .low_next (low_next)
  );

  assign accept    = bus.start & ~bus.flush;
  assign is_muldiv = (bus.op <= OP_DIVU);
  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign mag_rs    = (signed_op & bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign mag_rt    = (signed_op & bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  assign last_iter = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_muldiv) state_next = ST_BUSY;
      ST_BUSY: if (bus.flush || last_iter) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state == ST_BUSY);
    bus.stall = (state == ST_BUSY) & (bus.start | bus.rd_req);
  end

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Sign fix-up of the final iteration; a zero divisor bypasses it so HI
  // returns the dividend exactly as it was issued.
  always_comb begin
    prod     = {acc_next, low_next};
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (div_zero) begin
      hi_res = rs_hold;
      lo_res = '1;
    end else if (is_div) begin
      hi_res = sign_a ? -acc_next : acc_next;
      lo_res = (sign_a ^ sign_b) ? -low_next : low_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      low      <= '0;
      operand  <= '0;
      rs_hold  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              cnt      <= '0;
              acc      <= '0;
              low      <= mag_rs;
              operand  <= mag_rt;
              rs_hold  <= bus.rs_val;
              sign_a   <= signed_op & bus.rs_val[WIDTH-1];
              sign_b   <= signed_op & bus.rt_val[WIDTH-1];
              is_div   <= bus.op[1];
              div_zero <= bus.op[1] & (bus.rt_val == '0);
            end
            OP_MTHI: hi_q <= bus.rs_val;
            OP_MTLO: lo_q <= bus.rs_val;
            default: ;
          endcase
        end
      end else if (!bus.flush) begin
        acc <= acc_next;
        low <= low_next;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          hi_q   <= hi_res;
          lo_q   <= lo_res;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a done-driven scoreboard.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   done_count;
  exp_t sb_q[$];

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void check_output(input string name, input logic [63:0] act,
                                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got hi/lo %h_%h, required no done", bus.hi, bus.lo);
      end else begin
        e = sb_q.pop_front();
        check_output(e.name, {bus.hi, bus.lo}, e.val);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_output("idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [63:0] exp,
                                input string name);
    int n;
    int dc;
    wait_idle();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    sb_q.push_back('{name, exp});
    dc = done_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output({name, "_busy_cycles"}, 64'(n), 64'd32);
    check_output({name, "_done_high"}, {63'd0, bus.done}, 64'd1);
    @(negedge clk); #1;
    check_output({name, "_done_count"}, 64'(done_count - dc), 64'd1);
    @(posedge clk); #1;
    check_output({name, "_done_width"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int n;
    int dc;
    vectors     = 0;
    miscompares = 0;
    done_count  = 0;
    bus.start   = 1'b0;
    bus.op      = 3'd7;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.rd_req  = 1'b0;
    bus.flush   = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_output("reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check_output("reset_flags", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI / MTLO take effect at the sampling edge with no busy or done.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_val = 32'hA5A5_A5A5;
    #1;
    check_output("mthi_before_edge", {32'd0, bus.hi}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_output("mthi_hi", {32'd0, bus.hi}, 64'h0000_0000_A5A5_A5A5);
    check_output("mthi_busy", {63'd0, bus.busy}, 64'd0);
    bus.rd_req = 1'b1;
    @(negedge clk); #1;
    check_output("mfhi_idle_stall", {62'd0, bus.stall, bus.done}, 64'd0);
    bus.rd_req = 1'b0;
    bus.start = 1'b1; bus.op = OP_MTLO; bus.rs_val = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_output("mtlo_hi_lo", {bus.hi, bus.lo}, 64'hA5A5_A5A5_5A5A_5A5A);

    apply_stimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
    apply_stimulus(OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, "mult_neg3x7");
    apply_stimulus(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_min_sq");
    apply_stimulus(OP_MULT,  32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, "mult_min_x1");
    apply_stimulus(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_neg7_2");
    apply_stimulus(OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7_neg2");
    apply_stimulus(OP_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, "divu_7_2");
    apply_stimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_min_neg1");
    apply_stimulus(OP_DIVU,  32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF, "divu_by_zero");
    apply_stimulus(OP_DIV,   32'h8000_0000, 32'd0,         64'h8000_0000_FFFF_FFFF, "div_by_zero");

    // rd_req held through a sequence; a stray start mid-sequence is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    sb_q.push_back('{"multu_3x5_stall", 64'd15});
    dc = done_count;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.rd_req = 1'b1;
    n = 0;
    begin
      int stall_n = 0;
      while (bus.busy && n < 100) begin
        if (bus.stall) stall_n++;
        if (n == 5) begin
          bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_val = 32'hDEAD_BEEF;
        end
        if (n == 6) bus.start = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      check_output("stall_cycles", 64'(stall_n), 64'd32);
    end
    check_output("stall_busy_cycles", 64'(n), 64'd32);
    check_output("stall_after_busy", {63'd0, bus.stall}, 64'd0);
    bus.rd_req = 1'b0;
    @(negedge clk); #1;
    check_output("stall_done_count", 64'(done_count - dc), 64'd1);

    // Flush ten cycles into a sequence: back to idle, HI/LO untouched.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_val = 32'hFFFF_FFFF; bus.rt_val = 32'hFFFF_FFFF;
    dc = done_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_output("flush_busy", {63'd0, bus.busy}, 64'd0);
    check_output("flush_hi_lo", {bus.hi, bus.lo}, 64'd15);
    repeat (3) @(posedge clk);
    #1;
    check_output("flush_no_done", 64'(done_count - dc), 64'd0);

    // Flush on the same edge as start in IDLE discards the op.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MULT; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    @(posedge clk); #1;
    check_output("flush_start_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    bus.op = OP_MTHI; bus.rs_val = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check_output("flush_mthi_hi", {32'd0, bus.hi}, 64'd0);

    // Reset twenty cycles into a sequence clears everything without a clock edge.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    dc = done_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check_output("async_reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_output("reset_no_done", 64'(done_count - dc), 64'd0);
    check_output("reset_no_busy", {63'd0, bus.busy}, 64'd0);

    check_output("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with an owned HI/LO register pair; sits beside the EX-stage ALU.
- Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the single-cycle ALU cannot.
- Runs a 32-iteration shift-add / restoring-divide sequence under an FSM.
- Drives a stall to the pipeline so MFHI/MFLO and back-to-back mul/div wait for completion.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH; the counter width is derived.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  op request from EX, sampled on rising clk
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
- rs_val  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- rt_val  in  WIDTH  multiplier / divisor
- rd_req  in  1  EX holds MFHI/MFLO this cycle
- flush  in  1  pipeline flush; cancels an in-flight op
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, HI/LO just updated by mul/div
- stall  out  1  busy & (start | rd_req)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Async reset (rst_n=0): state=IDLE; hi=lo=0; busy=0; done=0; counter=0; internal accumulators=0.
- Reset mid-sequence aborts immediately; no partial HI/LO write.
- States are IDLE and BUSY. done is a registered flag, not a state.
- IDLE, start=1, op 0-3:
  - Latch operands.
  - Signed ops (MULT/DIV) take absolute values and record signs.
  - Go to BUSY with counter=0.
- IDLE, start=1, op 4/5: write rs_val into HI/LO at that edge; stay IDLE; no busy; no done.
- IDLE, start=1, op 6/7: ignored.
- BUSY:
  - One iteration per cycle; counter increments.
  - At the edge where counter==WIDTH-1, apply sign correction, write HI/LO, go to IDLE, set done=1 for exactly the next cycle.
- Latency: start sampled at edge E0 → busy=1 for cycles after E0 through E32 → HI/LO valid and done=1 after E32.
- start while BUSY is ignored; stall guarantees EX holds the instruction. Once busy falls, the held start is accepted normally.
- flush while BUSY: return to IDLE at that edge; HI/LO unchanged; no done.
- flush with start on the same edge in IDLE: flush wins; op discarded.
- Multiply:
  - {HI,LO} = 64-bit product.
  - MULT: negate the 64-bit result when sign_a ^ sign_b.
  - The 0x80000000 operand's absolute value is treated as unsigned 2^31, so the result is correct.
- Divide: LO = quotient, HI = remainder.
  - DIV: quotient negated when sign_a ^ sign_b; remainder takes the sign of the dividend, so truncation is toward zero.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor zero (DIV or DIVU): still 32 cycles; LO=0xFFFFFFFF, HI=rs_val as latched.
- No overflow flag: mul/div never trap.
- hi/lo outputs are direct register outputs. During BUSY they hold their old values.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants (OP_MULT..OP_MTLO)
  - FSM state enum
  - WIDTH default
- One sub-module, muldiv_iter: a combinational single step.
  - Multiply: conditional add and shift of the {acc,multiplier} pair.
  - Divide: trial subtract and shift of the {rem,quotient} pair.
  - The sequencer owns the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy exactly 32 cycles; done pulses once after E32; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xA5A5A5A5 then MFHI → HI updates next edge; busy=0; done=0.
- Mid-op events:
  - rd_req during BUSY → stall=1 until busy falls.
  - start during BUSY → ignored.
  - flush at cycle 10 → busy=0 next cycle; HI/LO unchanged; no done.
  - rst_n low at cycle 20 → all outputs 0 immediately, without waiting for clk.
